// File: rtl/controlador_jogo_if.sv
// Game-controller signal bundle: switch/strobe inputs towards the controller,
// phase, command pulses and score outputs back to the rest of the game.
interface controlador_jogo_if;
   logic       liga;
   logic       modo_ataque;
   logic       confirmar;
   logic       tick;
   logic       resultado_valido;
   logic       acerto;
   logic       repetido;
   logic       DESLIGADO;
   logic       PREPARACAO;
   logic       ATAQUE;
   logic       FIM;
   logic       grava_mapa;
   logic       dispara;
   logic [2:0] vida;
   logic [2:0] acertos;
   logic [4:0] jogadas;
   logic       vitoria;
   logic       derrota;
   logic       pisca;

   modport master (
      output liga, modo_ataque, confirmar, tick, resultado_valido, acerto, repetido,
      input  DESLIGADO, PREPARACAO, ATAQUE, FIM, grava_mapa, dispara,
      input  vida, acertos, jogadas, vitoria, derrota, pisca
   );

   modport slave (
      input  liga, modo_ataque, confirmar, tick, resultado_valido, acerto, repetido,
      output DESLIGADO, PREPARACAO, ATAQUE, FIM, grava_mapa, dispara,
      output vida, acertos, jogadas, vitoria, derrota, pisca
   );
endinterface

// File: rtl/controlador_jogo.sv
// Naval-battle game sequencer: phase FSM, map-store / fire commands,
// lives / hits / shots bookkeeping and the end-of-game blink.
module controlador_jogo #(
   parameter int unsigned VIDA_INICIAL  = 3,
   parameter int unsigned CELULAS_NAVIO = 5,
   parameter int unsigned TIMEOUT       = 15,
   parameter int unsigned PISCA_DIV     = 8
) (
   input logic               clock,
   input logic               reset,
   controlador_jogo_if.slave bus
);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned DW = $clog2(PISCA_DIV + 1);

   typedef enum logic [2:0] {S_DESL, S_PREP, S_ATQ, S_ESPERA, S_VIT, S_DER} state_t;

   state_t        state_q, state_d;
   logic          mapa_ok_q, mapa_ok_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [DW-1:0] div_q, div_d;
   logic [2:0]    vida_q, vida_d, acertos_q, acertos_d;
   logic [4:0]    jogadas_q, jogadas_d;
   logic          pisca_q, pisca_d;
   logic          grava_q, grava_d, dispara_q, dispara_d;
   logic          desl_q, prep_q, atq_q, fim_q, vit_q, der_q;
   logic [2:0]    vida_menos, acertos_mais;
   logic [4:0]    jogadas_mais;

   // Next-state and next-counter logic
   always_comb begin
      state_d      = state_q;
      mapa_ok_d    = mapa_ok_q;
      timer_d      = timer_q;
      div_d        = '0;
      vida_d       = vida_q;
      acertos_d    = acertos_q;
      jogadas_d    = jogadas_q;
      pisca_d      = 1'b0;
      grava_d      = 1'b0;
      dispara_d    = 1'b0;
      vida_menos   = (vida_q != 3'd0) ? vida_q - 3'd1 : 3'd0;
      acertos_mais = (acertos_q < 3'(CELULAS_NAVIO)) ? acertos_q + 3'd1 : acertos_q;
      jogadas_mais = (&jogadas_q) ? jogadas_q : jogadas_q + 5'd1;

      // A pending shot must resolve before the game can be switched off
      if (!bus.liga && state_q != S_ESPERA) begin
         state_d   = S_DESL;
         mapa_ok_d = 1'b0;
         timer_d   = '0;
         vida_d    = 3'(VIDA_INICIAL);
         acertos_d = 3'd0;
         jogadas_d = 5'd0;
      end else begin
         case (state_q)
            S_DESL: state_d = S_PREP;
            S_PREP: begin
               if (bus.modo_ataque && mapa_ok_q) state_d = S_ATQ;
               if (bus.confirmar) begin
                  grava_d   = 1'b1;
                  mapa_ok_d = 1'b1;
               end
            end
            S_ATQ: begin
               if (bus.confirmar) begin
                  dispara_d = 1'b1;
                  timer_d   = '0;
                  state_d   = S_ESPERA;
               end else if (!bus.modo_ataque) begin
                  state_d   = S_PREP;
                  vida_d    = 3'(VIDA_INICIAL);
                  acertos_d = 3'd0;
                  jogadas_d = 5'd0;
               end
            end
            S_ESPERA: begin
               if (bus.resultado_valido) begin
                  if (bus.repetido) begin
                     state_d = S_ATQ;
                  end else if (bus.acerto) begin
                     acertos_d = acertos_mais;
                     jogadas_d = jogadas_mais;
                     state_d   = (acertos_mais == 3'(CELULAS_NAVIO)) ? S_VIT : S_ATQ;
                  end else begin
                     vida_d    = vida_menos;
                     jogadas_d = jogadas_mais;
                     state_d   = (vida_menos == 3'd0) ? S_DER : S_ATQ;
                  end
               end else if (timer_q == TW'(TIMEOUT - 1)) begin
                  state_d = S_ATQ;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            S_VIT, S_DER: begin
               div_d   = div_q;
               pisca_d = pisca_q;
               if (bus.confirmar) begin
                  state_d   = S_PREP;
                  mapa_ok_d = 1'b0;
                  vida_d    = 3'(VIDA_INICIAL);
                  acertos_d = 3'd0;
                  jogadas_d = 5'd0;
                  div_d     = '0;
                  pisca_d   = 1'b0;
               end else if (bus.tick) begin
                  if (div_q == DW'(PISCA_DIV - 1)) begin
                     div_d   = '0;
                     pisca_d = ~pisca_q;
                  end else begin
                     div_d = div_q + DW'(1);
                  end
               end
            end
            default: state_d = S_DESL;
         endcase
      end
   end

   // State, counters and registered decode of the phase outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_DESL;
         mapa_ok_q <= 1'b0;
         timer_q   <= '0;
         div_q     <= '0;
         vida_q    <= 3'(VIDA_INICIAL);
         acertos_q <= 3'd0;
         jogadas_q <= 5'd0;
         pisca_q   <= 1'b0;
         grava_q   <= 1'b0;
         dispara_q <= 1'b0;
         desl_q    <= 1'b1;
         prep_q    <= 1'b0;
         atq_q     <= 1'b0;
         fim_q     <= 1'b0;
         vit_q     <= 1'b0;
         der_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mapa_ok_q <= mapa_ok_d;
         timer_q   <= timer_d;
         div_q     <= div_d;
         vida_q    <= vida_d;
         acertos_q <= acertos_d;
         jogadas_q <= jogadas_d;
         pisca_q   <= pisca_d;
         grava_q   <= grava_d;
         dispara_q <= dispara_d;
         desl_q    <= (state_d == S_DESL);
         prep_q    <= (state_d == S_PREP);
         atq_q     <= (state_d == S_ATQ) || (state_d == S_ESPERA);
         fim_q     <= (state_d == S_VIT) || (state_d == S_DER);
         vit_q     <= (state_d == S_VIT);
         der_q     <= (state_d == S_DER);
      end
   end

   assign bus.DESLIGADO  = desl_q;
   assign bus.PREPARACAO = prep_q;
   assign bus.ATAQUE     = atq_q;
   assign bus.FIM        = fim_q;
   assign bus.grava_mapa = grava_q;
   assign bus.dispara    = dispara_q;
   assign bus.vida       = vida_q;
   assign bus.acertos    = acertos_q;
   assign bus.jogadas    = jogadas_q;
   assign bus.vitoria    = vit_q;
   assign bus.derrota    = der_q;
   assign bus.pisca      = pisca_q;
endmodule

// File: tb/tb_controlador_jogo.sv
// Bench for controlador_jogo: directed game scenarios then random play, with a
// per-cycle expected-output queue filled by a rule-level game model.
module tb_controlador_jogo;
   localparam int VI = 3;
   localparam int CN = 5;
   localparam int TO = 15;
   localparam int PD = 8;

   localparam int P_OFF  = 0;
   localparam int P_PREP = 1;
   localparam int P_ATK  = 2;
   localparam int P_WAIT = 3;
   localparam int P_WON  = 4;
   localparam int P_LOST = 5;

   typedef struct packed {
      logic [3:0] fase;
      logic       grava;
      logic       disp;
      logic [2:0] vida;
      logic [2:0] acertos;
      logic [4:0] jogadas;
      logic       vit;
      logic       der;
      logic       pisca;
   } snap_t;

   logic clock;
   logic reset;
   controlador_jogo_if bus ();

   controlador_jogo #(
      .VIDA_INICIAL (VI),
      .CELULAS_NAVIO(CN),
      .TIMEOUT      (TO),
      .PISCA_DIV    (PD)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   snap_t exp_q[$];

   // stimulus variables
   logic rs, li, mo, co, ti, rv, ac, re;

   // game model state
   int m_fase, m_vida, m_hits, m_shots, m_wait, m_ticks;
   bit m_map, m_blink, m_grava, m_disp;

   task automatic new_game();
      m_vida  = VI;
      m_hits  = 0;
      m_shots = 0;
      m_blink = 0;
      m_ticks = 0;
   endtask

   task automatic model_step();
      m_grava = 0;
      m_disp  = 0;
      if (rs) begin
         m_fase = P_OFF;
         new_game();
         m_map  = 0;
         m_wait = 0;
      end else if (!li && m_fase != P_WAIT) begin
         m_fase = P_OFF;
         new_game();
         m_map = 0;
      end else begin
         case (m_fase)
            P_OFF: m_fase = P_PREP;
            P_PREP: begin
               if (mo && m_map) m_fase = P_ATK;
               if (co) begin
                  m_grava = 1;
                  m_map   = 1;
               end
            end
            P_ATK: begin
               if (co) begin
                  m_disp = 1;
                  m_fase = P_WAIT;
                  m_wait = 0;
               end else if (!mo) begin
                  m_fase = P_PREP;
                  new_game();
               end
            end
            P_WAIT: begin
               if (rv) begin
                  if (re) begin
                     m_fase = P_ATK;
                  end else if (ac) begin
                     m_hits  = (m_hits < CN) ? m_hits + 1 : CN;
                     m_shots = (m_shots < 31) ? m_shots + 1 : 31;
                     m_fase  = (m_hits == CN) ? P_WON : P_ATK;
                  end else begin
                     m_vida  = (m_vida > 0) ? m_vida - 1 : 0;
                     m_shots = (m_shots < 31) ? m_shots + 1 : 31;
                     m_fase  = (m_vida == 0) ? P_LOST : P_ATK;
                  end
               end else begin
                  m_wait++;
                  if (m_wait >= TO) m_fase = P_ATK;
               end
            end
            default: begin
               if (co) begin
                  m_fase = P_PREP;
                  new_game();
                  m_map = 0;
               end else if (ti) begin
                  m_ticks++;
                  if (m_ticks == PD) begin
                     m_ticks = 0;
                     m_blink = !m_blink;
                  end
               end
            end
         endcase
      end
   endtask

   function automatic snap_t model_snap();
      snap_t s;
      s.fase    = {m_fase == P_OFF, m_fase == P_PREP,
                   m_fase == P_ATK || m_fase == P_WAIT,
                   m_fase == P_WON || m_fase == P_LOST};
      s.grava   = m_grava;
      s.disp    = m_disp;
      s.vida    = 3'(m_vida);
      s.acertos = 3'(m_hits);
      s.jogadas = 5'(m_shots);
      s.vit     = (m_fase == P_WON);
      s.der     = (m_fase == P_LOST);
      s.pisca   = m_blink;
      return s;
   endfunction

   // one clock: apply inputs, predict, advance
   task automatic cycle();
      ti = 1'($urandom_range(0, 1));
      if (!rv) begin
         ac = 1'($urandom_range(0, 1));
         re = 1'($urandom_range(0, 1));
      end
      reset                = rs;
      bus.liga             = li;
      bus.modo_ataque      = mo;
      bus.confirmar        = co;
      bus.tick             = ti;
      bus.resultado_valido = rv;
      bus.acerto           = ac;
      bus.repetido         = re;
      model_step();
      exp_q.push_back(model_snap());
      @(posedge clock);
      #2;
      co = 0;
      rv = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // fire, wait `delay` cycles, then present one result
   task automatic shot(input int delay, input bit hit, input bit rep);
      co = 1;
      cycle();
      for (int i = 0; i < delay; i++) begin
         co = 1'($urandom_range(0, 1));
         cycle();
      end
      rv = 1;
      ac = hit;
      re = rep;
      cycle();
      cycle();
   endtask

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h want %0h", name, cyc, got, want);
      end
   endtask

   // monitor: compare DUT outputs with the oldest prediction each cycle
   initial begin
      snap_t e;
      forever begin
         @(posedge clock);
         #1;
         cyc++;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("fase", int'({bus.DESLIGADO, bus.PREPARACAO, bus.ATAQUE, bus.FIM}), int'(e.fase));
            chk("pulsos", int'({bus.grava_mapa, bus.dispara}), int'({e.grava, e.disp}));
            chk("vida", int'(bus.vida), int'(e.vida));
            chk("acertos", int'(bus.acertos), int'(e.acertos));
            chk("jogadas", int'(bus.jogadas), int'(e.jogadas));
            chk("resultado", int'({bus.vitoria, bus.derrota}), int'({e.vit, e.der}));
            chk("pisca", int'(bus.pisca), int'(e.pisca));
         end
      end
   end

   initial begin
      rs = 1; li = 0; mo = 0; co = 0; ti = 0; rv = 0; ac = 0; re = 0;
      m_fase = P_OFF; m_map = 0; m_wait = 0; m_grava = 0; m_disp = 0;
      new_game();
      idle(2);
      rs = 0;
      idle(1);
      li = 1;
      idle(1);
      mo = 1;
      idle(3);                     // no map yet: stays in preparation
      co = 1;
      idle(3);                     // store map, then attack
      for (int i = 0; i < CN; i++) shot(int'($urandom_range(0, 5)), 1, 0);
      idle(60);                    // victory blink
      co = 1;
      idle(3);                     // back to prep, map cleared
      co = 1;
      idle(3);
      for (int i = 0; i < VI; i++) shot(int'($urandom_range(0, 5)), 0, 0);
      idle(30);                    // defeat blink
      co = 1;
      idle(2);
      co = 1;
      idle(3);
      shot(2, 1, 1);               // repeated cell
      co = 1;
      idle(18);                    // timeout, no strobe
      shot(TO - 1, 1, 0);          // strobe on the last waiting cycle
      shot(TO, 1, 0);              // strobe one cycle too late
      shot(1, 0, 0);               // miss
      mo = 0;
      idle(2);                     // leave attack: counters reinitialised
      mo = 1;
      idle(2);
      co = 1;
      idle(1);
      li = 0;
      idle(3);                     // switch-off waits for the result
      rv = 1;
      ac = 0;
      re = 0;
      idle(3);
      li = 1;
      idle(2);
      co = 1;
      idle(3);
      li = 0;
      idle(1);                     // switch-off from attack
      li = 1;
      idle(2);
      co = 1;
      idle(3);
      co = 1;
      idle(1);
      rs = 1;
      idle(1);                     // reset mid-shot
      rs = 0;
      rv = 1;
      ac = 1;
      re = 0;
      idle(3);                     // late strobe ignored

      for (int i = 0; i < 800; i++) begin
         rs = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 49) == 0) li = ~li;
         else if (!li && $urandom_range(0, 3) == 0) li = 1;
         if ($urandom_range(0, 19) == 0) mo = ~mo;
         co = ($urandom_range(0, 5) == 0);
         rv = ($urandom_range(0, 3) == 0);
         ac = 1'($urandom_range(0, 1));
         re = ($urandom_range(0, 4) == 0);
         cycle();
      end
      rs = 0;
      idle(2);

      chk("fila_vazia", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/controlador_jogo.md
# controlador_jogo

Central sequencing FSM for the naval-battle game. It replaces the purely combinational switch decode of game state with a registered controller. It owns the phase (off / preparation / attack / end of game), issues single-cycle commands to the map selector (store map) and to the attack manager (fire). It also keeps lives, hit and move counters, and drives the end-of-game blink used by the LED matrix and the display.

## Interface
Parameters:
- VIDA_INICIAL, 3, lives at game start (1..7)
- CELULAS_NAVIO, 5, ship cells to hit for victory (1..7)
- TIMEOUT, 15, clock cycles to wait for an attack result before abandoning the shot
- PISCA_DIV, 8, `tick` pulses per half-period of `pisca`

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- liga  in  1  game-on switch level (ch7)
- modo_ataque  in  1  attack-phase request level (ch6)
- confirmar  in  1  debounced single-cycle confirm pulse
- tick  in  1  slow single-cycle enable, used for blinking only
- resultado_valido  in  1  attack manager result strobe
- acerto  in  1  result: hit; qualified by `resultado_valido`
- repetido  in  1  result: cell already attacked; qualified by `resultado_valido`; overrides `acerto`
- DESLIGADO, PREPARACAO, ATAQUE, FIM  out  1 each  one-hot phase outputs, registered
- grava_mapa  out  1  one-cycle pulse: map selector latches the current map
- dispara  out  1  one-cycle pulse: attack manager evaluates the current coordinate
- vida  out  3  lives remaining
- acertos  out  3  hits so far
- jogadas  out  5  valid shots so far, saturating at 31
- vitoria, derrota  out  1 each  end-of-game result, valid while FIM=1
- pisca  out  1  blink square wave; 0 outside FIM

## Operation
- States: S_DESL, S_PREP, S_ATQ, S_ESPERA, S_VIT, S_DER.
  - DESLIGADO=S_DESL.
  - PREPARACAO=S_PREP.
  - ATAQUE=S_ATQ or S_ESPERA.
  - FIM=S_VIT or S_DER.
- Priority, highest first:
  - `reset`.
  - `liga`=0 forces S_DESL, except from S_ESPERA, which finishes first.
  - The state-specific rules below.
- S_DESL:
  - Counters held at initial values; `mapa_ok` flag cleared.
  - `liga`=1 → S_PREP.
- S_PREP:
  - `confirmar` → `grava_mapa` pulse and set `mapa_ok`. A repeat confirm re-stores the map.
  - `modo_ataque`=1 with `mapa_ok`=1 → S_ATQ.
  - `modo_ataque`=1 with `mapa_ok`=0 → stay in S_PREP.
  - `confirmar` and the entry condition in the same cycle: store the map, enter S_ATQ next cycle.
- S_ATQ:
  - `confirmar` → `dispara` pulse, enter S_ESPERA, timer cleared.
  - `modo_ataque`=0 → S_PREP; `vida`, `acertos` and `jogadas` reinitialised, `mapa_ok` kept.
- S_ESPERA:
  - `confirmar` ignored; `modo_ataque` and `liga` are not evaluated until the shot resolves.
  - `resultado_valido` with `repetido`: no counter change → S_ATQ.
  - `resultado_valido` with hit: `acertos`+1 and `jogadas`+1. If the new `acertos`==CELULAS_NAVIO → S_VIT, else → S_ATQ.
  - `resultado_valido` with miss: `vida`−1 and `jogadas`+1. If the new `vida`==0 → S_DER, else → S_ATQ.
  - TIMEOUT cycles elapse without `resultado_valido`: no counter change → S_ATQ.
  - A strobe arriving on the timeout cycle wins over the timeout.
- S_VIT / S_DER:
  - `vitoria` or `derrota` held at 1.
  - `pisca` toggles every PISCA_DIV `tick`s.
  - `confirmar` → S_PREP with counters reinitialised and `mapa_ok` cleared.
  - `modo_ataque` ignored.
- Arithmetic:
  - `vida` never decrements below 0.
  - `acertos` never exceeds CELULAS_NAVIO.
  - `jogadas` saturates at 31.

## Timing
- All outputs are registered; phase outputs change on the clock edge after the triggering input is sampled.
- `grava_mapa` and `dispara` are high for exactly one cycle, the cycle after `confirmar` is sampled.
- Counters update on the same edge that leaves S_ESPERA.
- Result latency: the attack manager must strobe within TIMEOUT cycles after `dispara`.
- Reset values:
  - DESLIGADO=1; PREPARACAO=ATAQUE=FIM=0.
  - `grava_mapa`=`dispara`=0.
  - `vida`=VIDA_INICIAL; `acertos`=0; `jogadas`=0.
  - `vitoria`=`derrota`=0; `pisca`=0.
  - Timer, blink divider and `mapa_ok` cleared.
- Reset mid-shot abandons the pending result; a late strobe is ignored outside S_ESPERA.

## Test plan
- Reset, then `liga`=1 → PREPARACAO=1 one cycle later, `vida`=3. With `mapa_ok`=0, `modo_ataque`=1 → stays in PREPARACAO. After `confirmar`, `grava_mapa` is high for exactly 1 cycle, then ATAQUE=1.
- In ATAQUE, apply 5 `confirmar`/hit pairs → `dispara` pulses 5×, `acertos` steps 1..5, `jogadas`=5, FIM=1 and `vitoria`=1. `pisca` toggles every 8 `tick`s.
- Apply 3 misses → `vida` 3→2→1→0, `derrota`=1, `jogadas`=3. `confirmar` → PREPARACAO with `vida`=3, `jogadas`=0 and `mapa_ok` cleared.
- Results `repetido`=1 (with `acerto`=1), then no strobe for 15 cycles → counters unchanged both times, back to ATAQUE after each. A strobe on cycle 15 is counted.
- `liga`=0 during S_ESPERA → stays until the result, then DESLIGADO. `liga`=0 during S_ATQ → DESLIGADO next cycle.
- Assert `reset` in S_ESPERA, then a late strobe → all outputs at reset values and the strobe ignored.
